// File: rtl/carry_slice_adder.sv
// Multi-cycle adder that resolves SLICE bits per clock through one carry segment.
// Operands shift down one slice per RUN cycle while the result shifts in from the top.
module carry_slice_adder #(
  parameter int         WIDTH  = 32,
  parameter int         SLICE  = 8,
  parameter logic [1:0] C_INIT = 2'b00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             carryinitin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout
);

  // state   | meaning
  // S_IDLE  | waiting for start; result registers hold last add
  // S_RUN   | one slice added per cycle, low slice first
  // S_DONE  | single-cycle done pulse, result valid

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [IDX_W-1:0] r_idx;
  logic [SLICE:0]   w_slice;
  logic             w_cin;
  logic             w_accept;
  logic             w_last;

  always_comb begin
    w_cin = 1'b0;
    case (C_INIT)
      2'b01:   w_cin = 1'b1;
      2'b10:   w_cin = carryinitin;
      default: w_cin = 1'b0;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_idx == LAST_IDX);
  assign w_slice  = {1'b0, r_opa[SLICE-1:0]} + {1'b0, r_opb[SLICE-1:0]}
                  + {{SLICE{1'b0}}, r_carry};

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // output logic
  always_comb begin
    busy     = (r_state == S_RUN);
    done     = (r_state == S_DONE);
    sum      = r_sum;
    carryout = r_cout;
  end

  // Datapath: low slice always sits at bit 0 of the operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_opa   <= opa;
      r_opb   <= opb;
      r_carry <= w_cin;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_opa   <= {{SLICE{1'b0}}, r_opa[WIDTH-1:SLICE]};
      r_opb   <= {{SLICE{1'b0}}, r_opb[WIDTH-1:SLICE]};
      r_sum   <= {w_slice[SLICE-1:0], r_sum[WIDTH-1:SLICE]};
      r_carry <= w_slice[SLICE];
      r_idx   <= r_idx + IDX_W'(1);
      if (w_last) begin
        r_cout <= w_slice[SLICE];
      end
    end
  end

endmodule

// File: tb/tb_carry_slice_adder.sv
// Bench for carry_slice_adder: one instance per C_INIT setting, directed
// corner cases plus random adds checked against plain 33-bit arithmetic.
module tb_carry_slice_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_r [4];
  logic [31:0] opa_r   [4];
  logic [31:0] opb_r   [4];
  logic        cii_r   [4];
  wire         busy_w  [4];
  wire         done_w  [4];
  wire  [31:0] sum_w   [4];
  wire         cout_w  [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  carry_slice_adder #(.WIDTH(32), .SLICE(8), .C_INIT(2'b00)) u_c0 (
    .clk(clk), .rst(rst), .start(start_r[0]), .opa(opa_r[0]), .opb(opb_r[0]),
    .carryinitin(cii_r[0]), .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]),
    .carryout(cout_w[0]));
  carry_slice_adder #(.WIDTH(32), .SLICE(8), .C_INIT(2'b01)) u_c1 (
    .clk(clk), .rst(rst), .start(start_r[1]), .opa(opa_r[1]), .opb(opb_r[1]),
    .carryinitin(cii_r[1]), .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]),
    .carryout(cout_w[1]));
  carry_slice_adder #(.WIDTH(32), .SLICE(8), .C_INIT(2'b10)) u_c2 (
    .clk(clk), .rst(rst), .start(start_r[2]), .opa(opa_r[2]), .opb(opb_r[2]),
    .carryinitin(cii_r[2]), .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]),
    .carryout(cout_w[2]));
  carry_slice_adder #(.WIDTH(32), .SLICE(8), .C_INIT(2'b11)) u_c3 (
    .clk(clk), .rst(rst), .start(start_r[3]), .opa(opa_r[3]), .opb(opb_r[3]),
    .carryinitin(cii_r[3]), .busy(busy_w[3]), .done(done_w[3]), .sum(sum_w[3]),
    .carryout(cout_w[3]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: carry-in chosen from the C_INIT of instance i, then plain addition.
  function automatic logic [32:0] model(input int i, input logic [31:0] a,
                                        input logic [31:0] b, input logic ci);
    logic cin;
    cin = (i == 1) ? 1'b1 : ((i == 2) ? ci : 1'b0);
    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
  endfunction

  task automatic do_add(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input string tag);
    logic [32:0] exp;
    int          lat;
    bit          seen;
    exp = model(i, a, b, ci);
    @(negedge clk);
    start_r[i] = 1'b1; opa_r[i] = a; opb_r[i] = b; cii_r[i] = ci;
    @(posedge clk);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (done_w[i]) begin
        seen = 1'b1;
      end else begin
        chk({tag, "_busy_run"}, 64'(busy_w[i]), 64'd1);
        // Late starts and operand churn must not disturb the add in flight.
        start_r[i] = 1'b1; opa_r[i] = $urandom; opb_r[i] = $urandom; cii_r[i] = ~ci;
        @(posedge clk);
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'd5);
    chk({tag, "_busy_at_done"}, 64'(busy_w[i]), 64'd0);
    chk({tag, "_result"}, {31'd0, cout_w[i], sum_w[i]}, {31'd0, exp});
    start_r[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_r[i] = 1'b0;
    chk({tag, "_idle_no_accept"}, {62'd0, busy_w[i], done_w[i]}, 64'd0);
    chk({tag, "_hold"}, {31'd0, cout_w[i], sum_w[i]}, {31'd0, exp});
  endtask

  logic [31:0] a_hist [64];
  logic [31:0] b_hist [64];

  initial begin
    int last_done;
    int n_done;
    int quiet;
    for (int i = 0; i < 4; i++) begin
      start_r[i] = 1'b0; opa_r[i] = '0; opb_r[i] = '0; cii_r[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_state_%0d", i),
          {29'd0, busy_w[i], done_w[i], cout_w[i], sum_w[i]}, 64'd0);
    end
    rst = 1'b0;

    // Accepted on the very first edge with rst low.
    do_add(0, 32'h0000_0001, 32'h0000_0002, 1'b0, "basic_1p2");
    do_add(1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "cinit01_ripple");
    do_add(2, 32'h0000_00FF, 32'h0000_0000, 1'b1, "cinit10_ci1");
    do_add(2, 32'h0000_00FF, 32'h0000_0000, 1'b0, "cinit10_ci0");
    do_add(3, 32'h8000_0000, 32'h8000_0000, 1'b1, "cinit11_ignore");
    do_add(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, "wrap_allones");
    do_add(0, 32'h00FF_00FF, 32'h0001_0001, 1'b0, "slice_carry");

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) begin
        do_add(i, $urandom, $urandom, 1'($urandom_range(0, 1)),
               $sformatf("rand_c%0d_%0d", i, k));
      end
    end

    // Reset dominates a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start_r[0] = 1'b1; opa_r[0] = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start_r[0] = 1'b0;
    chk("rst_vs_start_busy", 64'(busy_w[0]), 64'd0);

    // Reset two cycles into a run aborts it with no done pulse.
    start_r[0] = 1'b1; opa_r[0] = 32'hDEAD_BEEF; opb_r[0] = 32'h1111_1111;
    @(posedge clk);
    @(negedge clk);
    start_r[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs", {29'd0, busy_w[0], done_w[0], cout_w[0], sum_w[0]}, 64'd0);
    quiet = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (done_w[0]) quiet++;
    end
    chk("abort_no_done", 64'(quiet), 64'd0);
    do_add(0, 32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, "after_abort");

    // start held high: one add per 6 cycles, each using its acceptance-edge operands.
    last_done = -1; n_done = 0;
    for (int t = 0; t < 40; t++) begin
      start_r[0] = 1'b1; opa_r[0] = $urandom; opb_r[0] = $urandom;
      @(posedge clk);
      a_hist[t] = opa_r[0]; b_hist[t] = opb_r[0];
      @(negedge clk);
      if (done_w[0]) begin
        n_done++;
        chk($sformatf("stream_phase_t%0d", t), 64'(t % 6), 64'd4);
        if (t >= 4)
          chk($sformatf("stream_result_t%0d", t), {31'd0, cout_w[0], sum_w[0]},
              {31'd0, model(0, a_hist[t-4], b_hist[t-4], 1'b0)});
        if (last_done >= 0)
          chk($sformatf("stream_spacing_t%0d", t), 64'(t - last_done), 64'd6);
        last_done = t;
      end
    end
    start_r[0] = 1'b0;
    chk("stream_done_count", 64'(n_done), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
